// File: rtl/next_pc_unit.sv
// Registered program-counter stage for the fetch front end: redirect priority,
// target alignment checking and a one-deep pending redirect held across fetch stalls.
module next_pc_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              IALIGN       = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            branchTaken,
    input  logic [XLEN-1:0] branchTarget,
    input  logic            jumpValid,
    input  logic [XLEN-1:0] jumpTarget,
    input  logic            trapValid,
    input  logic [XLEN-1:0] trapVector,
    input  logic            fetchReady,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pcPlus4,
    output logic            fetchValid,
    output logic            misaligned,
    output logic [XLEN-1:0] misalignedAddr
);

    localparam int ALIGN_LSB = (IALIGN == 16) ? 1 : 2;
    localparam int MIS_BIT   = (IALIGN == 16) ? 0 : 1;
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-ALIGN_LSB){1'b1}}, {ALIGN_LSB{1'b0}}};

    typedef enum logic {
        BOOT,
        RUN
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            fetch_valid_q, fetch_valid_d;
    logic            pend_valid_q, pend_valid_d;
    logic [XLEN-1:0] pend_target_q, pend_target_d;
    logic            pend_is_trap_q, pend_is_trap_d;
    logic            mis_q, mis_d;
    logic [XLEN-1:0] mis_addr_q, mis_addr_d;

    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] trap_aligned;
    logic [XLEN-1:0] cand_target;
    logic            cand_bad;
    logic            live_valid;
    logic            live_is_trap;
    logic [XLEN-1:0] live_target;
    logic            accept;

    assign pc_plus4     = pc_q + XLEN'(4);
    assign trap_aligned = trapVector & ALIGN_MASK;
    assign accept       = fetch_valid_q && fetchReady;

    // Only a jump/branch that beats any trap is alignment-checked; a bad one becomes a trap redirect.
    assign cand_target  = jumpValid ? {jumpTarget[XLEN-1:1], 1'b0} : branchTarget;
    assign cand_bad     = !trapValid && (jumpValid || branchTaken) && cand_target[MIS_BIT];
    assign live_valid   = trapValid || jumpValid || branchTaken;
    assign live_is_trap = trapValid || cand_bad;
    assign live_target  = live_is_trap ? trap_aligned : cand_target;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d        = RUN;
        fetch_valid_d  = 1'b1;
        pc_d           = pc_q;
        pend_valid_d   = pend_valid_q;
        pend_target_d  = pend_target_q;
        pend_is_trap_d = pend_is_trap_q;
        mis_d          = cand_bad;
        mis_addr_d     = cand_bad ? cand_target : mis_addr_q;

        case (state_q)
            BOOT:    fetch_valid_d = (state_d == RUN);
            RUN:     fetch_valid_d = 1'b1;
            default: state_d       = BOOT;
        endcase

        if (accept) begin
            if (live_valid) begin
                pc_d = live_target;
            end else if (pend_valid_q) begin
                pc_d = pend_target_q;
            end else begin
                pc_d = pc_plus4;
            end
            pend_valid_d = 1'b0;
        end else if (live_valid && !(pend_valid_q && pend_is_trap_q && !live_is_trap)) begin
            // A captured trap is sticky: only another trap may replace it.
            pend_valid_d   = 1'b1;
            pend_target_d  = live_target;
            pend_is_trap_d = live_is_trap;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= BOOT;
            pc_q           <= RESET_VECTOR;
            fetch_valid_q  <= 1'b0;
            pend_valid_q   <= 1'b0;
            pend_target_q  <= '0;
            pend_is_trap_q <= 1'b0;
            mis_q          <= 1'b0;
            mis_addr_q     <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            fetch_valid_q  <= fetch_valid_d;
            pend_valid_q   <= pend_valid_d;
            pend_target_q  <= pend_target_d;
            pend_is_trap_q <= pend_is_trap_d;
            mis_q          <= mis_d;
            mis_addr_q     <= mis_addr_d;
        end
    end

    assign pc             = pc_q;
    assign pcPlus4        = pc_plus4;
    assign fetchValid     = fetch_valid_q;
    assign misaligned     = mis_q;
    assign misalignedAddr = mis_addr_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// Bench for next_pc_unit: directed vector table, hand-written reset sequences and
// randomized traffic against a rule-level reference model, on IALIGN=32 and IALIGN=16 instances.
module tb_next_pc_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        branchTaken, jumpValid, trapValid, fetchReady;
    logic [31:0] branchTarget, jumpTarget, trapVector;

    logic [31:0] pc_a, pp4_a, maddr_a;
    logic        fv_a, mis_a;
    logic [31:0] pc_b, pp4_b, maddr_b;
    logic        fv_b, mis_b;

    next_pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0000_0100), .IALIGN(32)) dut_a (
        .clk(clk), .reset(reset),
        .branchTaken(branchTaken), .branchTarget(branchTarget),
        .jumpValid(jumpValid), .jumpTarget(jumpTarget),
        .trapValid(trapValid), .trapVector(trapVector),
        .fetchReady(fetchReady),
        .pc(pc_a), .pcPlus4(pp4_a), .fetchValid(fv_a),
        .misaligned(mis_a), .misalignedAddr(maddr_a)
    );

    next_pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0000_0000), .IALIGN(16)) dut_b (
        .clk(clk), .reset(reset),
        .branchTaken(branchTaken), .branchTarget(branchTarget),
        .jumpValid(jumpValid), .jumpTarget(jumpTarget),
        .trapValid(trapValid), .trapVector(trapVector),
        .fetchReady(fetchReady),
        .pc(pc_b), .pcPlus4(pp4_b), .fetchValid(fv_b),
        .misaligned(mis_b), .misalignedAddr(maddr_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: index 0 = IALIGN 32 (reset 0x100), index 1 = IALIGN 16 (reset 0).
    logic [31:0] m_pc[2];
    logic        m_run[2];
    logic        m_pv[2];
    logic [31:0] m_pt[2];
    logic        m_ptrap[2];
    logic        m_mis[2];
    logic [31:0] m_maddr[2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k]    = (k == 0) ? 32'h0000_0100 : 32'h0;
            m_run[k]   = 1'b0;
            m_pv[k]    = 1'b0;
            m_pt[k]    = 32'h0;
            m_ptrap[k] = 1'b0;
            m_mis[k]   = 1'b0;
            m_maddr[k] = 32'h0;
        end
    endtask

    task automatic model_step(input int k);
        int unsigned bytes;
        logic        has, is_trap, bad;
        logic [31:0] raw, tgt;
        bytes   = (k == 0) ? 4 : 2;
        has     = trapValid || jumpValid || branchTaken;
        bad     = 1'b0;
        is_trap = 1'b0;
        raw     = 32'h0;
        if (trapValid) begin
            is_trap = 1'b1;
        end else if (jumpValid) begin
            raw = (jumpTarget / 2) * 2;
            bad = (raw % bytes) != 0;
        end else if (branchTaken) begin
            raw = branchTarget;
            bad = (raw % bytes) != 0;
        end
        if (bad) is_trap = 1'b1;
        tgt = is_trap ? (trapVector / bytes) * bytes : raw;
        m_mis[k] = bad;
        if (bad) m_maddr[k] = raw;
        if (m_run[k] && fetchReady) begin
            if (has)          m_pc[k] = tgt;
            else if (m_pv[k]) m_pc[k] = m_pt[k];
            else              m_pc[k] = m_pc[k] + 32'd4;
            m_pv[k] = 1'b0;
        end else if (has && !(m_pv[k] && m_ptrap[k] && !is_trap)) begin
            m_pv[k]    = 1'b1;
            m_pt[k]    = tgt;
            m_ptrap[k] = is_trap;
        end
        m_run[k] = 1'b1;
    endtask

    task automatic compare_all(input string tag);
        check({tag, " pc32"},    pc_a,    m_pc[0]);
        check({tag, " pp4_32"},  pp4_a,   m_pc[0] + 32'd4);
        check({tag, " fv32"},    {31'b0, fv_a},  {31'b0, m_run[0]});
        check({tag, " mis32"},   {31'b0, mis_a}, {31'b0, m_mis[0]});
        check({tag, " maddr32"}, maddr_a, m_maddr[0]);
        check({tag, " pc16"},    pc_b,    m_pc[1]);
        check({tag, " pp4_16"},  pp4_b,   m_pc[1] + 32'd4);
        check({tag, " fv16"},    {31'b0, fv_b},  {31'b0, m_run[1]});
        check({tag, " mis16"},   {31'b0, mis_b}, {31'b0, m_mis[1]});
        check({tag, " maddr16"}, maddr_b, m_maddr[1]);
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        if (!reset) begin
            model_step(0);
            model_step(1);
        end
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic drive(input logic fr, input logic bt, input logic [31:0] btgt,
                         input logic jv, input logic [31:0] jtgt,
                         input logic tv, input logic [31:0] tvec);
        fetchReady   = fr;
        branchTaken  = bt;
        branchTarget = btgt;
        jumpValid    = jv;
        jumpTarget   = jtgt;
        trapValid    = tv;
        trapVector   = tvec;
    endtask

    typedef struct {
        logic        fr;
        logic        bt;
        logic [31:0] btgt;
        logic        jv;
        logic [31:0] jtgt;
        logic        tv;
        logic [31:0] tvec;
        logic [31:0] exp_pc;
        logic        exp_mis;
        logic [31:0] exp_maddr;
    } vec_t;

    function automatic vec_t mk(input logic fr, input logic bt, input logic [31:0] btgt,
                                input logic jv, input logic [31:0] jtgt,
                                input logic tv, input logic [31:0] tvec,
                                input logic [31:0] exp_pc, input logic exp_mis,
                                input logic [31:0] exp_maddr);
        vec_t v;
        v.fr = fr; v.bt = bt; v.btgt = btgt; v.jv = jv; v.jtgt = jtgt;
        v.tv = tv; v.tvec = tvec; v.exp_pc = exp_pc; v.exp_mis = exp_mis;
        v.exp_maddr = exp_maddr;
        return v;
    endfunction

    vec_t tbl[25];

    initial begin
        // Expected values refer to the IALIGN=32 instance after the row's clock edge.
        tbl[0]  = mk(1, 0, 0,        0, 0,            0, 0,     32'h100,       0, 0);
        tbl[1]  = mk(1, 0, 0,        0, 0,            0, 0,     32'h104,       0, 0);
        tbl[2]  = mk(1, 0, 0,        0, 0,            0, 0,     32'h108,       0, 0);
        tbl[3]  = mk(1, 0, 0,        1, 32'h200,      0, 0,     32'h200,       0, 0);
        tbl[4]  = mk(1, 1, 32'h300,  1, 32'h400,      1, 32'h800, 32'h800,     0, 0);
        tbl[5]  = mk(1, 0, 0,        1, 32'h40,       0, 0,     32'h40,        0, 0);
        tbl[6]  = mk(0, 1, 32'h80,   0, 0,            0, 0,     32'h40,        0, 0);
        tbl[7]  = mk(0, 0, 0,        0, 0,            0, 0,     32'h40,        0, 0);
        tbl[8]  = mk(0, 0, 0,        0, 0,            0, 0,     32'h40,        0, 0);
        tbl[9]  = mk(1, 0, 0,        0, 0,            0, 0,     32'h80,        0, 0);
        tbl[10] = mk(1, 0, 0,        0, 0,            0, 0,     32'h84,        0, 0);
        tbl[11] = mk(0, 0, 0,        0, 0,            1, 32'h10, 32'h84,       0, 0);
        tbl[12] = mk(0, 0, 0,        1, 32'h500,      0, 0,     32'h84,        0, 0);
        tbl[13] = mk(1, 0, 0,        0, 0,            0, 0,     32'h10,        0, 0);
        tbl[14] = mk(0, 1, 32'h300,  0, 0,            0, 0,     32'h10,        0, 0);
        tbl[15] = mk(0, 0, 0,        1, 32'h500,      0, 0,     32'h10,        0, 0);
        tbl[16] = mk(1, 0, 0,        0, 0,            0, 0,     32'h500,       0, 0);
        tbl[17] = mk(1, 1, 32'h1002, 0, 0,            0, 32'h800, 32'h800,     1, 32'h1002);
        tbl[18] = mk(1, 0, 0,        0, 0,            0, 32'h800, 32'h804,     0, 32'h1002);
        tbl[19] = mk(1, 0, 0,        1, 32'h1003,     0, 32'h800, 32'h800,     1, 32'h1002);
        tbl[20] = mk(1, 0, 0,        0, 0,            0, 0,     32'h804,       0, 32'h1002);
        tbl[21] = mk(1, 0, 0,        0, 0,            1, 32'h807, 32'h804,     0, 32'h1002);
        tbl[22] = mk(1, 0, 0,        1, 32'hFFFF_FFFC, 0, 0,    32'hFFFF_FFFC, 0, 32'h1002);
        tbl[23] = mk(1, 0, 0,        0, 0,            0, 0,     32'h0,         0, 32'h1002);
        tbl[24] = mk(0, 1, 32'h300,  0, 0,            0, 0,     32'h0,         0, 32'h1002);

        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        compare_all("reset");
        check("reset pc32 literal", pc_a, 32'h0000_0100);

        reset = 1'b0;
        check("boot fv32", {31'b0, fv_a}, 32'h0);

        for (int i = 0; i < 25; i++) begin
            drive(tbl[i].fr, tbl[i].bt, tbl[i].btgt, tbl[i].jv, tbl[i].jtgt,
                  tbl[i].tv, tbl[i].tvec);
            cycle("tbl");
            check($sformatf("tbl[%0d] pc", i), pc_a, tbl[i].exp_pc);
            check($sformatf("tbl[%0d] pcPlus4", i), pp4_a, tbl[i].exp_pc + 32'd4);
            check($sformatf("tbl[%0d] fv", i), {31'b0, fv_a}, 32'h1);
            check($sformatf("tbl[%0d] mis", i), {31'b0, mis_a}, {31'b0, tbl[i].exp_mis});
            check($sformatf("tbl[%0d] maddr", i), maddr_a, tbl[i].exp_maddr);
            if (i == 17) begin
                check("ialign16 accepts 0x1002", pc_b, 32'h1002);
                check("ialign16 no mis", {31'b0, mis_b}, 32'h0);
            end
        end

        // Mid-stall reset: the branch captured in the last row must never reach pc.
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        model_reset();
        check("async reset pc32", pc_a, 32'h100);
        check("async reset fv32", {31'b0, fv_a}, 32'h0);
        @(negedge clk);
        compare_all("in reset");
        reset = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 0);
        cycle("post reset");
        check("post reset boot pc", pc_a, 32'h100);
        cycle("post reset");
        check("pending discarded", pc_a, 32'h104);
        cycle("post reset");
        check("post reset seq", pc_a, 32'h108);

        for (int n = 0; n < 1500; n++) begin
            logic [31:0] bt_r, jt_r, tv_r;
            bt_r = $urandom & 32'hFFFF_FFFE;
            if ($urandom_range(3) != 0) bt_r[1] = 1'b0;
            jt_r = $urandom;
            if ($urandom_range(3) != 0) jt_r[1] = 1'b0;
            tv_r = $urandom;
            drive($urandom_range(9) < 7, $urandom_range(3) == 0, bt_r,
                  $urandom_range(4) == 0, jt_r, $urandom_range(9) == 0, tv_r);
            reset = ($urandom_range(99) == 0);
            if (reset) model_reset();
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/next_pc_unit.md
# next_pc_unit

Registered program-counter stage for the RISC-V core's fetch front end. It replaces the purely combinational two-way next-PC select with a parametrised unit that:
- holds the PC register;
- prioritises sequential, branch, jump and trap redirects;
- checks target alignment;
- handshakes with instruction memory, so stalls never lose a redirect.

It sits between the execute stage (branch/jump resolution), the trap logic and the instruction-fetch port.

## Interface
Parameters:
- XLEN, 32, datapath/address width.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset (XLEN bits).
- IALIGN, 32, instruction alignment in bits. Legal values are 32 and 16. A target is misaligned if bit 1 is set (IALIGN=32) or bit 0 is set (IALIGN=16).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- branchTaken  input  1  conditional branch resolved taken this cycle.
- branchTarget  input  XLEN  branch target address.
- jumpValid  input  1  JAL/JALR redirect this cycle.
- jumpTarget  input  XLEN  jump target. Bit 0 is forced to 0 before use.
- trapValid  input  1  trap/exception redirect this cycle.
- trapVector  input  XLEN  trap handler address. The low log2(IALIGN/8) bits are forced to 0.
- fetchReady  input  1  instruction memory accepts the current pc.
- pc  output  XLEN  current fetch address (registered).
- pcPlus4  output  XLEN  pc + 4, combinational, modulo 2^XLEN.
- fetchValid  output  1  pc is a valid fetch request (registered).
- misaligned  output  1  one-cycle pulse: a redirect target was misaligned.
- misalignedAddr  output  XLEN  offending target, held until the next misaligned event.

## Operation
- States:
  - BOOT: reset state, fetchValid=0. Always moves to RUN on the next clock.
  - RUN: fetchValid=1. Stays in RUN until reset.
- Redirect priority within a cycle: trap > jump > branch > sequential.
- Alignment check:
  - Applies to the winning jump or branch target only.
  - A misaligned target is replaced by the aligned trapVector.
  - misaligned pulses high on the next cycle; misalignedAddr captures the raw target.
- Handshake: a fetch is accepted when fetchValid && fetchReady.
- On acceptance, the next pc is, in order:
  1. this cycle's winning redirect, if any;
  2. else the pending redirect, if pendValid;
  3. else pcPlus4.
- pendValid is cleared on acceptance.
- When no fetch is accepted (BOOT, or RUN with fetchReady=0):
  - pc holds.
  - A redirect arriving this cycle is written into the one-deep pending register (pendValid, pendTarget, pendIsTrap).
  - A new redirect overwrites the pending one, except that a pending trap is never overwritten by a non-trap redirect.
  - A misaligned check is performed when the redirect is captured, not when it is applied.
- pc may wrap: pc = 2^XLEN−4 accepted with no redirect gives next pc = 0.
- pcPlus4 is the only combinational output.

## Timing
- Reset values (asynchronous, immediate):
  - pc = RESET_VECTOR
  - fetchValid = 0
  - state = BOOT
  - pendValid = 0
  - misaligned = 0
  - misalignedAddr = 0
- First cycle after reset release: BOOT. fetchValid rises after the first clock edge.
- Redirect-to-pc latency is 1 cycle: a redirect sampled at edge N appears on pc after edge N, provided the fetch is accepted at N.
- A redirect captured during a stall appears on pc one cycle after the edge where fetchReady is next sampled high.
- A redirect and the release of a pending one in the same accepted cycle: the live redirect wins and the pending one is discarded.
- Reset asserted mid-stall discards the pending redirect.
- misaligned is registered. It is high for exactly one cycle after the capturing or applying edge.

## Test plan
1. Reset and sequential fetch:
   - Stimulus: RESET_VECTOR=0x100; release reset; fetchReady=1.
   - Response: fetchValid=0 in the first cycle, then pc sequence 0x100, 0x104, 0x108.
2. Priority:
   - Stimulus: at pc=0x200, assert trapValid (trapVector=0x800), jumpValid (0x400) and branchTaken (0x300) together.
   - Response: next pc=0x800; no misaligned pulse.
3. Stall capture:
   - Stimulus: fetchReady=0 at pc=0x40; branchTaken to 0x80 for one cycle; fetchReady held low 3 cycles, then high.
   - Response: pc holds 0x40; after release, pc=0x80, then 0x84.
4. Pending trap protection:
   - Stimulus: during a stall, trap to 0x10, then a jump to 0x500 on the next cycle.
   - Response: after release pc=0x10 (jump dropped).
   - Stimulus: in a separate stall, a branch to 0x300 then a jump to 0x500.
   - Response: after release pc=0x500.
5. Misalignment:
   - Stimulus: IALIGN=32; branch target 0x1002; trapVector=0x800.
   - Response: next pc=0x800; misaligned=1 for one cycle; misalignedAddr=0x1002.
   - Stimulus: jumpTarget=0x1003.
   - Response: bit 0 cleared gives 0x1002, which is misaligned; misaligned pulses.
   - Stimulus: IALIGN=16; target 0x1002.
   - Response: accepted, pc=0x1002.
6. Wrap and mid-stall reset:
   - Stimulus: pc=0xFFFF_FFFC accepted with no redirect.
   - Response: next pc=0x0, pcPlus4=0x4.
   - Stimulus: capture a redirect during a stall, then assert reset.
   - Response: pc=RESET_VECTOR; the pending redirect is never applied.
